// File: rtl/fft_sample_loader.sv
// fft_sample_loader
//   Buffers one frame of NUMSAMPLES serial samples and answers the fft's
//   ld_data/ld_done load handshake by presenting the frame four words per
//   cycle. Sample n goes to bank (n mod 4) at bank address (n div 4).
//
// Ports
//   clk        clock, all logic on posedge
//   rst_n      synchronous reset, active low
//   s_valid    upstream sample valid
//   s_ready    loader accepts a sample (only in FILL, low during reset)
//   s_data     upstream sample word
//   ld_data    load request from the fft (pulse or level)
//   ld_done    frame fully presented; held while ld_data stays high
//   ld_valid   data_in0..3 / ld_addr carry a valid group this cycle
//   ld_addr    bank address of the current group
//   data_in0-3 bank 0..3 words, sample 4*ld_addr+K
//   frame_rdy  buffer holds a complete frame
module fft_sample_loader #(
  parameter int WORDSIZE   = 16,
  parameter int NUMSAMPLES = 32,
  parameter int ADDRSIZE   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WORDSIZE-1:0] s_data,
  input  logic                ld_data,
  output logic                ld_done,
  output logic                ld_valid,
  output logic [ADDRSIZE-1:0] ld_addr,
  output logic [WORDSIZE-1:0] data_in0,
  output logic [WORDSIZE-1:0] data_in1,
  output logic [WORDSIZE-1:0] data_in2,
  output logic [WORDSIZE-1:0] data_in3,
  output logic                frame_rdy
);

  // Sample index is {group, bank}, so it is two bits wider than the group address.
  localparam int CNTW = ADDRSIZE + 2;
  localparam logic [CNTW-1:0]     LAST_SMP = CNTW'(NUMSAMPLES - 1);
  localparam logic [ADDRSIZE-1:0] LAST_GRP = ADDRSIZE'(NUMSAMPLES / 4 - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_READY,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNTW-1:0]     r_count;
  logic                r_req_pend;
  logic [WORDSIZE-1:0] r_buf [NUMSAMPLES];

  logic                w_accept;
  logic                w_last_smp;
  logic                w_last_grp;
  logic                w_load_entry;
  logic                w_req_capture;
  logic [ADDRSIZE-1:0] w_grp_nxt_p0;

  logic                r_vld_p1;
  logic                r_done_p1;
  logic                r_frame_rdy_p1;
  logic [ADDRSIZE-1:0] r_ld_addr_p1;
  logic [WORDSIZE-1:0] r_dat_p1 [4];

  // Ready is a pure function of state, forced low while reset is asserted.
  assign s_ready       = rst_n && (r_state == ST_FILL);
  assign w_accept      = s_ready && s_valid;
  assign w_last_smp    = (r_count == LAST_SMP);
  assign w_last_grp    = (r_ld_addr_p1 == LAST_GRP);
  assign w_load_entry  = (r_state == ST_READY) && (w_state_nxt == ST_LOAD);
  // Requests are only remembered while the frame is still being built or waiting.
  assign w_req_capture = ld_data && ((r_state == ST_FILL) || (r_state == ST_READY));

  // Next-state and next-group selection
  always_comb begin
    w_state_nxt  = r_state;
    w_grp_nxt_p0 = '0;
    case (r_state)
      ST_FILL: begin
        if (w_accept && w_last_smp) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        // A request seen this very cycle counts, not only the latched one.
        if (r_req_pend || ld_data) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_grp_nxt_p0 = r_ld_addr_p1 + ADDRSIZE'(1);
        if (w_last_grp) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!ld_data) w_state_nxt = ST_FILL;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_req_pend <= 1'b0;
    end else begin
      // No wrap: after the last sample FILL is left, so the count restarts at 0.
      if (w_accept) r_count <= w_last_smp ? '0 : r_count + CNTW'(1);
      if (w_load_entry)       r_req_pend <= 1'b0;
      else if (w_req_capture) r_req_pend <= 1'b1;
    end
  end

  // Frame buffer; contents are don't-care after reset, so it carries none.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_count] <= s_data;
  end

  // Output register stage (p1): loaded from the next state so that group i
  // is on the outputs during LOAD cycle i.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1       <= 1'b0;
      r_done_p1      <= 1'b0;
      r_frame_rdy_p1 <= 1'b0;
      r_ld_addr_p1   <= '0;
      for (int k = 0; k < 4; k++) r_dat_p1[k] <= '0;
    end else begin
      r_vld_p1       <= (w_state_nxt == ST_LOAD);
      r_done_p1      <= (w_state_nxt == ST_DONE);
      r_frame_rdy_p1 <= (w_state_nxt != ST_FILL);
      // Data and address hold their last group whenever no group is presented.
      if (w_state_nxt == ST_LOAD) begin
        r_ld_addr_p1 <= w_grp_nxt_p0;
        for (int k = 0; k < 4; k++) r_dat_p1[k] <= r_buf[{w_grp_nxt_p0, 2'(k)}];
      end
    end
  end

  assign ld_valid  = r_vld_p1;
  assign ld_done   = r_done_p1;
  assign frame_rdy = r_frame_rdy_p1;
  assign ld_addr   = r_ld_addr_p1;
  assign data_in0  = r_dat_p1[0];
  assign data_in1  = r_dat_p1[1];
  assign data_in2  = r_dat_p1[2];
  assign data_in3  = r_dat_p1[3];

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb_fft_sample_loader
//   Directed bench for fft_sample_loader (WORDSIZE=16, NUMSAMPLES=32).
//   Inputs change just after the falling edge; outputs are sampled on the
//   falling edge, i.e. half a cycle after the rising edge that produced them.
module tb_fft_sample_loader;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        ld_data;
  logic        ld_done;
  logic        ld_valid;
  logic [2:0]  ld_addr;
  logic [15:0] data_in0;
  logic [15:0] data_in1;
  logic [15:0] data_in2;
  logic [15:0] data_in3;
  logic        frame_rdy;

  int n_chk = 0;
  int n_err = 0;

  fft_sample_loader #(
    .WORDSIZE  (16),
    .NUMSAMPLES(32),
    .ADDRSIZE  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .ld_data  (ld_data),
    .ld_done  (ld_done),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .data_in2 (data_in2),
    .data_in3 (data_in3),
    .frame_rdy(frame_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample, accepted on the next rising edge.
  task automatic push(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    chk("s_ready_fill", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called in the READY cycle that sees the request. Expects 8 groups of
  // base+4i+K, then DONE; with hold=1 ld_data stays high for 4 DONE cycles.
  task automatic run_load(input logic [15:0] base, input bit hold);
    logic [15:0] e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!hold) ld_data = 1'b0;
      chk("ld_valid_load", 32'(ld_valid), 32'd1);
      chk("ld_addr", 32'(ld_addr), 32'(i));
      e = base + 16'(4 * i);
      chk("data_in0", 32'(data_in0), 32'(e));
      chk("data_in1", 32'(data_in1), 32'(e + 16'd1));
      chk("data_in2", 32'(data_in2), 32'(e + 16'd2));
      chk("data_in3", 32'(data_in3), 32'(e + 16'd3));
      chk("ld_done_load", 32'(ld_done), 32'd0);
      chk("s_ready_load", 32'(s_ready), 32'd0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("ld_valid_done", 32'(ld_valid), 32'd0);
    chk("ld_done_rise", 32'(ld_done), 32'd1);
    chk("s_ready_done", 32'(s_ready), 32'd0);
    chk("data_hold", 32'(data_in3), 32'(base + 16'd31));
    if (hold) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk("ld_done_held", 32'(ld_done), 32'd1);
        chk("ld_valid_held", 32'(ld_valid), 32'd0);
      end
      ld_data = 1'b0;
    end
    @(negedge clk);
    chk("ld_done_fall", 32'(ld_done), 32'd0);
    chk("s_ready_refill", 32'(s_ready), 32'd1);
    chk("frame_rdy_refill", 32'(frame_rdy), 32'd0);
  endtask

  task automatic chk_ready_state;
    chk("frame_rdy_set", 32'(frame_rdy), 32'd1);
    chk("s_ready_ready", 32'(s_ready), 32'd0);
    chk("ld_valid_ready", 32'(ld_valid), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'h0;
    ld_data = 1'b0;

    // T1 reset
    repeat (2) @(negedge clk);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk("rst_ld_addr", 32'(ld_addr), 32'd0);
    chk("rst_data", {data_in0, data_in1}, 32'd0);
    chk("rst_data2", {data_in2, data_in3}, 32'd0);
    chk("rst_frame_rdy", 32'(frame_rdy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);

    // T2 ramp frame, pulse request in READY
    for (int n = 0; n < 32; n++) push(16'(n));
    chk_ready_state();
    ld_data = 1'b1;
    run_load(16'd0, 1'b0);

    // T3 early request during FILL, random gaps
    for (int n = 0; n < 6; n++) begin
      idle($urandom_range(0, 2));
      push(16'(100 + n));
    end
    ld_data = 1'b1;
    @(negedge clk);
    ld_data = 1'b0;
    chk("early_no_load", 32'(ld_valid), 32'd0);
    for (int n = 6; n < 31; n++) begin
      idle($urandom_range(0, 2));
      push(16'(100 + n));
    end
    idle(1);
    chk("early_frame_rdy_partial", 32'(frame_rdy), 32'd0);
    chk("early_no_load2", 32'(ld_valid), 32'd0);
    push(16'd131);
    chk_ready_state();
    run_load(16'd100, 1'b0);

    // T4 level handshake
    for (int n = 0; n < 32; n++) push(16'(500 + n));
    chk_ready_state();
    ld_data = 1'b1;
    run_load(16'd500, 1'b1);

    // T5 backpressure past the last sample
    for (int n = 0; n < 32; n++) push(16'(200 + n));
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    repeat (2) begin
      chk_ready_state();
      @(negedge clk);
    end
    ld_data = 1'b1;
    run_load(16'd200, 1'b0);

    // Last sample and request on the same cycle
    for (int n = 0; n < 31; n++) push(16'(700 + n));
    ld_data = 1'b1;
    push(16'd731);
    ld_data = 1'b0;
    chk_ready_state();
    run_load(16'd700, 1'b0);

    // T6 abort on LOAD cycle 3
    for (int n = 0; n < 32; n++) push(16'(300 + n));
    ld_data = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_data = 1'b0;
      chk("abort_addr", 32'(ld_addr), 32'(i));
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ld_valid", 32'(ld_valid), 32'd0);
    chk("abort_ld_done", 32'(ld_done), 32'd0);
    chk("abort_frame_rdy", 32'(frame_rdy), 32'd0);
    chk("abort_data0", 32'(data_in0), 32'd0);
    chk("abort_s_ready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    ld_data = 1'b1;
    @(negedge clk);
    ld_data = 1'b0;
    chk("abort_fill", 32'(s_ready), 32'd1);
    chk("abort_no_done", 32'(ld_done), 32'd0);
    chk("abort_no_load", 32'(ld_valid), 32'd0);
    for (int n = 0; n < 31; n++) push(16'(400 + n));
    chk("fresh_partial", 32'(frame_rdy), 32'd0);
    chk("fresh_no_load", 32'(ld_valid), 32'd0);
    push(16'd431);
    chk_ready_state();
    run_load(16'd400, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
